// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single 8-bit RAM port.
// Registers the winner's request onto the RAM bus and returns read data with an ack pulse.
module mem_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic       write,
    input  logic [7:0] from_memory,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic {ARB, ACCESS} state_e;

    state_e     state_q, state_d;
    logic [7:0] address_q, address_d;
    logic [7:0] to_memory_q, to_memory_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       write_q, write_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       is_wr_q, is_wr_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pick1;

    // last_q set means port 1 won most recently
    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0) begin
            pick1 = 1'b1;
        end else if (req0 && req1 && FIXED_PRIO == 0) begin
            pick1 = ~last_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        to_memory_d = to_memory_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        write_d     = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        is_wr_d     = is_wr_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ARB: begin
                if (req0 || req1) begin
                    address_d   = pick1 ? addr1 : addr0;
                    to_memory_d = pick1 ? wdata1 : wdata0;
                    write_d     = pick1 ? we1 : we0;
                    is_wr_d     = pick1 ? we1 : we0;
                    grant_d     = pick1 ? 2'b10 : 2'b01;
                    last_d      = pick1;
                    cnt_d       = 3'(RD_LAT);
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    if (!is_wr_q) begin
                        if (grant_q[1]) rdata1_d = from_memory;
                        else            rdata0_d = from_memory;
                    end
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    grant_d = 2'b00;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            address_q   <= 8'h00;
            to_memory_q <= 8'h00;
            rdata0_q    <= 8'h00;
            rdata1_q    <= 8'h00;
            write_q     <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            cnt_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            to_memory_q <= to_memory_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            write_q     <= write_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            is_wr_q     <= is_wr_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
        end
    end

    assign address   = address_q;
    assign to_memory = to_memory_q;
    assign write     = write_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign grant     = grant_q;
    assign busy      = (state_q == ACCESS);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RD_LAT=1 round-robin, RD_LAT=1 fixed
// priority, RD_LAT=3 round-robin), each with its own latency-pipelined RAM model.
module tb_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       req0 [3];
    logic       req1 [3];
    logic       we0 [3];
    logic       we1 [3];
    logic [7:0] addr0 [3];
    logic [7:0] addr1 [3];
    logic [7:0] wdata0 [3];
    logic [7:0] wdata1 [3];
    logic       ack0 [3];
    logic       ack1 [3];
    logic [7:0] rdata0 [3];
    logic [7:0] rdata1 [3];
    logic [7:0] address [3];
    logic [7:0] to_memory [3];
    logic [7:0] from_memory [3];
    logic       write [3];
    logic       busy [3];
    logic [1:0] grant [3];

    typedef struct {
        int         inst;
        int         port;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;

    exp_t       sbq [$];
    exp_t       e;
    logic [7:0] shadow [3][256];
    logic [7:0] exp_rd [3][2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int FP  = (g == 1) ? 1 : 0;
        logic [7:0] mem [256];
        logic [7:0] pipe [LAT];

        mem_arbiter #(.RD_LAT(LAT), .FIXED_PRIO(FP)) u_dut (
            .clock(clock), .reset(reset),
            .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]),
            .wdata0(wdata0[g]), .ack0(ack0[g]), .rdata0(rdata0[g]),
            .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]),
            .wdata1(wdata1[g]), .ack1(ack1[g]), .rdata1(rdata1[g]),
            .address(address[g]), .to_memory(to_memory[g]),
            .write(write[g]), .from_memory(from_memory[g]),
            .grant(grant[g]), .busy(busy[g])
        );

        always @(posedge clock) begin
            if (reset) begin
                for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'h3C;
            end else if (write[g]) begin
                mem[address[g]] <= to_memory[g];
            end
            pipe[0] <= mem[address[g]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign from_memory[g] = pipe[LAT-1];
    end

    function automatic int lat(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    // Scoreboard: every ack pops the oldest expectation for port, cycle and rdata
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (((p == 0) ? ack0[i] : ack1[i]) === 1'b1) begin
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL sb_ack: unexpected ack inst %0d port %0d cycle %0d",
                                     i, p, cyc);
                        end else begin
                            e = sbq.pop_front();
                            if (e.inst != i || e.port != p || e.cyc != cyc ||
                                ((p == 0) ? rdata0[i] : rdata1[i]) !== e.rdata) begin
                                errors++;
                                $display("FAIL sb_ack: got inst %0d port %0d cycle %0d rdata %h, want inst %0d port %0d cycle %0d rdata %h",
                                         i, p, cyc, (p == 0) ? rdata0[i] : rdata1[i],
                                         e.inst, e.port, e.cyc, e.rdata);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input int p, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
        end else begin
            req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
        end
    endtask

    task automatic drop(input int i, input int p);
        if (p == 0) req0[i] = 1'b0;
        else        req1[i] = 1'b0;
    endtask

    task automatic push(input int i, input int p, input logic w,
                        input logic [7:0] a, input logic [7:0] d, input int c);
        exp_t x;
        if (w) shadow[i][a] = d;
        else   exp_rd[i][p] = shadow[i][a];
        x.inst = i; x.port = p; x.rdata = exp_rd[i][p]; x.cyc = c;
        sbq.push_back(x);
    endtask

    task automatic clear_model();
        sbq.delete();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 256; a++) shadow[i][a] = 8'(a) ^ 8'h3C;
            exp_rd[i][0] = 8'h00;
            exp_rd[i][1] = 8'h00;
        end
    endtask

    task automatic reset_all();
        for (int i = 0; i < 3; i++) begin
            drive(i, 0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(i, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic do_txn(input int i, input int p, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
        int t, wcnt, bcnt;
        bit ok, got;
        logic [1:0] g1;
        g1 = (p == 0) ? 2'b01 : 2'b10;
        @(negedge clock);
        drive(i, p, 1'b1, w, a, d);
        t = cyc;
        push(i, p, w, a, d, t + lat(i) + 2);
        wcnt = 0; bcnt = 0; ok = 1'b1; got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clock);
            if (write[i] === 1'b1) wcnt++;
            if (busy[i] === 1'b1) begin
                bcnt++;
                if (address[i] !== a || grant[i] !== g1 ||
                    (w && to_memory[i] !== d)) ok = 1'b0;
            end
            if (((p == 0) ? ack0[i] : ack1[i]) === 1'b1) begin
                got = 1'b1;
                drop(i, p);
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_ack: inst %0d port %0d no ack within 30 cycles", i, p);
            drop(i, p);
        end
        checks++;
        if (wcnt != (w ? 1 : 0)) begin
            errors++;
            $display("FAIL write_len: inst %0d got %0d want %0d", i, wcnt, w ? 1 : 0);
        end
        checks++;
        if (bcnt != lat(i) + 1) begin
            errors++;
            $display("FAIL busy_len: inst %0d got %0d want %0d", i, bcnt, lat(i) + 1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bus_stable: inst %0d address/grant/to_memory moved, want addr %h grant %b",
                     i, a, g1);
        end
    endtask

    task automatic run_pair(input int i, input int n0, input int n1);
        int c0, c1;
        bit done;
        c0 = 0; c1 = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clock);
            if (ack0[i] === 1'b1) begin
                c0++;
                if (c0 >= n0) drop(i, 0);
            end
            if (ack1[i] === 1'b1) begin
                c1++;
                if (c1 >= n1) drop(i, 1);
            end
            done = (c0 >= n0) && (c1 >= n1);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL pair_done: inst %0d acks %0d/%0d want %0d/%0d", i, c0, c1, n0, n1);
            drop(i, 0);
            drop(i, 1);
        end
    endtask

    task automatic test_reset();
        reset_all();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({grant[i], write[i], busy[i], ack0[i], ack1[i]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl: inst %0d got %b want 000000", i,
                         {grant[i], write[i], busy[i], ack0[i], ack1[i]});
            end
            checks++;
            if ({address[i], to_memory[i], rdata0[i], rdata1[i]} !== 32'h0) begin
                errors++;
                $display("FAIL reset_data: inst %0d got %h want 0", i,
                         {address[i], to_memory[i], rdata0[i], rdata1[i]});
            end
        end
    endtask

    task automatic test_write_read();
        reset_all();
        do_txn(0, 0, 1'b1, 8'h10, 8'h5A);
        do_txn(0, 0, 1'b0, 8'h10, 8'h00);
    endtask

    task automatic test_round_robin();
        int t;
        reset_all();
        @(negedge clock);
        drive(0, 0, 1'b1, 1'b0, 8'h21, 8'h00);
        drive(0, 1, 1'b1, 1'b0, 8'h42, 8'h00);
        t = cyc;
        for (int k = 0; k < 6; k++)
            push(0, k % 2, 1'b0, (k % 2 == 0) ? 8'h21 : 8'h42, 8'h00, t + 3 * (k + 1));
        run_pair(0, 3, 3);
    endtask

    task automatic test_fixed_prio();
        int t;
        reset_all();
        @(negedge clock);
        drive(1, 0, 1'b1, 1'b0, 8'h07, 8'h00);
        drive(1, 1, 1'b1, 1'b0, 8'h08, 8'h00);
        t = cyc;
        for (int k = 0; k < 3; k++) push(1, 0, 1'b0, 8'h07, 8'h00, t + 3 * (k + 1));
        push(1, 1, 1'b0, 8'h08, 8'h00, t + 12);
        run_pair(1, 3, 1);
    endtask

    task automatic test_rd_lat3();
        reset_all();
        do_txn(2, 1, 1'b1, 8'hFF, 8'hC3);
        do_txn(2, 1, 1'b0, 8'hFF, 8'h00);
    endtask

    task automatic test_reset_mid();
        int t2;
        reset_all();
        do_txn(2, 1, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        drive(2, 1, 1'b1, 1'b1, 8'h80, 8'h99);
        @(negedge clock);
        checks++;
        if (write[2] !== 1'b1 || grant[2] !== 2'b10) begin
            errors++;
            $display("FAIL mid_first: write %b grant %b want 1 10", write[2], grant[2]);
        end
        drive(2, 0, 1'b1, 1'b0, 8'h05, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({write[2], grant[2], busy[2], ack0[2], ack1[2]} !== 6'b0) begin
            errors++;
            $display("FAIL mid_ctrl: got %b want 000000",
                     {write[2], grant[2], busy[2], ack0[2], ack1[2]});
        end
        checks++;
        if (rdata1[2] !== 8'h00 || rdata0[2] !== 8'h00) begin
            errors++;
            $display("FAIL mid_rdata: got %h %h want 00 00", rdata0[2], rdata1[2]);
        end
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        t2 = cyc;
        push(2, 0, 1'b0, 8'h05, 8'h00, t2 + 5);
        push(2, 1, 1'b1, 8'h80, 8'h99, t2 + 10);
        @(negedge clock);
        checks++;
        if (grant[2] !== 2'b01) begin
            errors++;
            $display("FAIL mid_regrant: grant %b want 01", grant[2]);
        end
        run_pair(2, 1, 1);
    endtask

    task automatic test_back_to_back();
        int t, n;
        reset_all();
        @(negedge clock);
        drive(0, 0, 1'b1, 1'b0, 8'h30, 8'h00);
        t = cyc;
        for (int k = 0; k < 4; k++) push(0, 0, 1'b0, 8'(8'h30 + k), 8'h00, t + 3 * (k + 1));
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clock);
            if (ack0[0] === 1'b1) begin
                n++;
                if (n < 4) drive(0, 0, 1'b1, 1'b0, 8'(8'h30 + n), 8'h00);
                else       drop(0, 0);
            end
        end
        checks++;
        if (n != 4 || cyc != t + 12) begin
            errors++;
            $display("FAIL b2b_count: acks %0d at cycle %0d want 4 at %0d", n, cyc, t + 12);
            drop(0, 0);
        end
        do_txn(0, 0, 1'b1, 8'h31, 8'h77);
        checks++;
        if (rdata0[0] !== 8'h0F || rdata1[0] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_rdata: got %h %h want 0f 00", rdata0[0], rdata1[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_prio();
        test_rd_lat3();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clock);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected acks never seen, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
